// File: rtl/mesif_line_ctrl_pkg.sv
// Shared encodings for the MESIF line controller: opcodes, bus ops, snoop results,
// line states and controller FSM states.
package mesif_line_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_RD_L1D  = 4'd0,
        OP_WR_L1D  = 4'd1,
        OP_RD_L1I  = 4'd2,
        OP_SNP_INV = 4'd3,
        OP_SNP_RD  = 4'd4,
        OP_SNP_WR  = 4'd5,
        OP_SNP_RFO = 4'd6,
        OP_CLEAR   = 4'd8,
        OP_PRINT   = 4'd9
    } opcode_e;

    typedef enum logic [2:0] {
        BUS_READ  = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_INVAL = 3'd3,
        BUS_RFO   = 3'd4,
        BUS_NOP   = 3'd5
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'd0,
        SNP_HITM  = 2'd1,
        SNP_NOHIT = 2'd2
    } snoop_e;

    typedef enum logic [2:0] {
        LN_M = 3'd0,
        LN_E = 3'd1,
        LN_S = 3'd2,
        LN_I = 3'd3,
        LN_F = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_DUMP,
        FSM_DONE
    } fsm_e;

    function automatic logic is_cpu_op(input logic [3:0] opc);
        return (opc == OP_RD_L1D) || (opc == OP_WR_L1D) || (opc == OP_RD_L1I);
    endfunction

endpackage

// File: rtl/mesif_line_ctrl_if.sv
// Request/response/dump bundle between the command decoder (master) and the
// MESIF line controller (slave).
interface mesif_line_ctrl_if
    import mesif_line_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int WAY_BITS   = 2
);
    logic                  op_valid;
    logic                  op_ready;
    logic [3:0]            opcode;
    logic [INDEX_BITS-1:0] index;
    logic [WAY_BITS-1:0]   way;
    snoop_e                snoop_in;

    logic                  resp_valid;
    bus_op_e               bus_op;
    snoop_e                snoop_out;
    state_e                state_prev;
    state_e                state_new;
    logic                  op_err;

    logic                  dump_valid;
    logic [INDEX_BITS-1:0] dump_index;
    logic [WAY_BITS-1:0]   dump_way;
    state_e                dump_state;

    modport master (
        output op_valid, opcode, index, way, snoop_in,
        input  op_ready, resp_valid, bus_op, snoop_out, state_prev, state_new, op_err,
        input  dump_valid, dump_index, dump_way, dump_state
    );

    modport slave (
        input  op_valid, opcode, index, way, snoop_in,
        output op_ready, resp_valid, bus_op, snoop_out, state_prev, state_new, op_err,
        output dump_valid, dump_index, dump_way, dump_state
    );

endinterface

// File: rtl/mesif_next_state.sv
// Combinational MESIF transition table: (opcode, current state, snoop_in) ->
// (next state, bus op, our snoop response, illegal-opcode flag).
module mesif_next_state
    import mesif_line_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  state_e     cur_state,
    input  snoop_e     snoop_in,
    output state_e     next_state,
    output bus_op_e    bus_op,
    output snoop_e     snoop_out,
    output logic       err
);

    always_comb begin
        next_state = cur_state;
        bus_op     = BUS_NOP;
        snoop_out  = SNP_NOHIT;
        err        = 1'b0;
        case (opcode)
            OP_RD_L1D, OP_RD_L1I: begin
                if (cur_state == LN_I) begin
                    bus_op     = BUS_READ;
                    next_state = (snoop_in == SNP_HIT || snoop_in == SNP_HITM) ? LN_F : LN_E;
                end
            end
            OP_WR_L1D: begin
                next_state = LN_M;
                case (cur_state)
                    LN_I:       bus_op = BUS_RFO;
                    LN_S, LN_F: bus_op = BUS_INVAL;
                    default:    bus_op = BUS_NOP;
                endcase
            end
            OP_SNP_INV: begin
                if (cur_state == LN_S || cur_state == LN_F) begin
                    next_state = LN_I;
                    snoop_out  = SNP_HIT;
                end
            end
            OP_SNP_RD: begin
                case (cur_state)
                    LN_M: begin
                        next_state = LN_S;
                        snoop_out  = SNP_HITM;
                        bus_op     = BUS_WRITE;
                    end
                    LN_E, LN_S, LN_F: begin
                        next_state = LN_S;
                        snoop_out  = SNP_HIT;
                    end
                    default: ;
                endcase
            end
            OP_SNP_RFO: begin
                case (cur_state)
                    LN_M: begin
                        next_state = LN_I;
                        snoop_out  = SNP_HITM;
                        bus_op     = BUS_WRITE;
                    end
                    LN_E, LN_S, LN_F: begin
                        next_state = LN_I;
                        snoop_out  = SNP_HIT;
                    end
                    default: ;
                endcase
            end
            OP_CLEAR:             next_state = LN_I;
            OP_SNP_WR, OP_PRINT:  ;
            default:              err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mesif_line_ctrl.sv
// MESIF coherence controller owning every line state of a SETS x WAYS cache,
// with clear and a multi-cycle print sweep. Optional counters: MESIF_STATS_EN.
module mesif_line_ctrl
    import mesif_line_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int WAY_BITS   = 2,
    parameter int CNT_BITS   = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    mesif_line_ctrl_if.slave   bus
`ifdef MESIF_STATS_EN
    ,
    output logic [CNT_BITS-1:0] cpu_hit_cnt,
    output logic [CNT_BITS-1:0] cpu_miss_cnt,
    output logic [CNT_BITS-1:0] wb_cnt
`endif
);

    localparam int ADDR_BITS = INDEX_BITS + WAY_BITS;
    localparam int NLINES    = 1 << ADDR_BITS;

    state_e                 r_lines [NLINES];
    fsm_e                   r_fsm;
    fsm_e                   w_fsm_next;
    logic [ADDR_BITS-1:0]   r_sweep;

    logic                   r_resp_valid;
    bus_op_e                r_bus_op;
    snoop_e                 r_snoop_out;
    state_e                 r_state_prev;
    state_e                 r_state_new;
    logic                   r_op_err;
    logic                   r_dump_valid;
    logic [ADDR_BITS-1:0]   r_dump_addr;
    state_e                 r_dump_state;

    logic                   w_op_ready;
    logic                   w_accept_single;
    logic                   w_accept_print;
    logic                   w_is_clear;
    logic                   w_sweep_last;
    logic [ADDR_BITS-1:0]   w_addr;
    state_e                 w_cur;
    state_e                 w_ns_state;
    bus_op_e                w_ns_bus;
    snoop_e                 w_ns_snoop;
    logic                   w_ns_err;

    // Way is the low part of the line address so the sweep walks ways fastest.
    assign w_addr       = {bus.index, bus.way};
    assign w_cur        = r_lines[w_addr];
    assign w_is_clear   = (bus.opcode == OP_CLEAR);
    assign w_sweep_last = &r_sweep;

    mesif_next_state u_next_state (
        .opcode     (bus.opcode),
        .cur_state  (w_cur),
        .snoop_in   (bus.snoop_in),
        .next_state (w_ns_state),
        .bus_op     (w_ns_bus),
        .snoop_out  (w_ns_snoop),
        .err        (w_ns_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_fsm <= FSM_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next      = r_fsm;
        w_op_ready      = 1'b0;
        w_accept_single = 1'b0;
        w_accept_print  = 1'b0;
        case (r_fsm)
            FSM_IDLE: begin
                w_op_ready = 1'b1;
                if (bus.op_valid) begin
                    if (bus.opcode == OP_PRINT) begin
                        w_accept_print = 1'b1;
                        w_fsm_next     = FSM_DUMP;
                    end else begin
                        w_accept_single = 1'b1;
                    end
                end
            end
            FSM_DUMP: if (w_sweep_last) w_fsm_next = FSM_DONE;
            FSM_DONE: w_fsm_next = FSM_IDLE;
            default:  w_fsm_next = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NLINES; i++) r_lines[i] <= LN_I;
            r_sweep      <= '0;
            r_resp_valid <= 1'b0;
            r_bus_op     <= BUS_NOP;
            r_snoop_out  <= SNP_NOHIT;
            r_state_prev <= LN_I;
            r_state_new  <= LN_I;
            r_op_err     <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_state <= LN_I;
        end else begin
            r_resp_valid <= 1'b0;
            r_dump_valid <= 1'b0;
            if (w_accept_single) begin
                r_resp_valid <= 1'b1;
                r_bus_op     <= w_ns_bus;
                r_snoop_out  <= w_ns_snoop;
                r_op_err     <= w_ns_err;
                r_state_prev <= w_is_clear ? LN_I : w_cur;
                r_state_new  <= w_ns_state;
                if (w_is_clear) begin
                    for (int i = 0; i < NLINES; i++) r_lines[i] <= LN_I;
                end else if (!w_ns_err) begin
                    r_lines[w_addr] <= w_ns_state;
                end
            end
            if (w_accept_print) r_sweep <= '0;
            if (r_fsm == FSM_DUMP) begin
                r_dump_valid <= (r_lines[r_sweep] != LN_I);
                r_dump_addr  <= r_sweep;
                r_dump_state <= r_lines[r_sweep];
                r_sweep      <= r_sweep + 1'b1;
                // The completion pulse lands in the DONE cycle, alongside the last entry.
                if (w_sweep_last) begin
                    r_resp_valid <= 1'b1;
                    r_bus_op     <= BUS_NOP;
                    r_snoop_out  <= SNP_NOHIT;
                    r_op_err     <= 1'b0;
                end
            end
        end
    end

    assign bus.op_ready   = w_op_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.bus_op     = r_bus_op;
    assign bus.snoop_out  = r_snoop_out;
    assign bus.state_prev = r_state_prev;
    assign bus.state_new  = r_state_new;
    assign bus.op_err     = r_op_err;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_index = r_dump_addr[ADDR_BITS-1:WAY_BITS];
    assign bus.dump_way   = r_dump_addr[WAY_BITS-1:0];
    assign bus.dump_state = r_dump_state;

`ifdef MESIF_STATS_EN
    logic [CNT_BITS-1:0] r_hit_cnt;
    logic [CNT_BITS-1:0] r_miss_cnt;
    logic [CNT_BITS-1:0] r_wb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || (w_accept_single && w_is_clear)) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else if (w_accept_single) begin
            if (is_cpu_op(bus.opcode)) begin
                if (w_cur != LN_I) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                end else begin
                    if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                end
            end
            if (w_ns_bus == BUS_WRITE && r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 1'b1;
        end
    end

    assign cpu_hit_cnt  = r_hit_cnt;
    assign cpu_miss_cnt = r_miss_cnt;
    assign wb_cnt       = r_wb_cnt;
`else
    // Counter width only shapes the statistics build.
    if (CNT_BITS < 1) begin : g_cnt_bits_unused
    end
`endif

endmodule

// File: tb/tb_mesif_line_ctrl.sv
// Directed self-checking bench for mesif_line_ctrl (16 sets x 4 ways); the
// counter section runs only when MESIF_STATS_EN is defined.
module tb_mesif_line_ctrl;
    import mesif_line_ctrl_pkg::*;

    localparam int IB = 4;
    localparam int WB = 2;
    localparam int CB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesif_line_ctrl_if #(.INDEX_BITS(IB), .WAY_BITS(WB)) bus ();

`ifdef MESIF_STATS_EN
    logic [CB-1:0] hit_cnt;
    logic [CB-1:0] miss_cnt;
    logic [CB-1:0] wbk_cnt;
`endif

    mesif_line_ctrl #(.INDEX_BITS(IB), .WAY_BITS(WB), .CNT_BITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MESIF_STATS_EN
        ,
        .cpu_hit_cnt  (hit_cnt),
        .cpu_miss_cnt (miss_cnt),
        .wb_cnt       (wbk_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    int busy, ndump, nresp, resp_bus;
    int d_addr [8];
    int d_state[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] opc, input int idx, input int w, input snoop_e snp);
        logic [31:0] iv;
        logic [31:0] wv;
        iv = idx;
        wv = w;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = opc;
        bus.index    = iv[IB-1:0];
        bus.way      = wv[WB-1:0];
        bus.snoop_in = snp;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.snoop_in = SNP_NOHIT;
    endtask

    task automatic chk_resp(input string tag, input bus_op_e eb, input snoop_e es,
                            input state_e ep, input state_e en, input logic eerr);
        $display("txn %s: resp_valid=%0d bus_op=%0d snoop_out=%0d prev=%0d new=%0d err=%0d",
                 tag, bus.resp_valid, bus.bus_op, bus.snoop_out, bus.state_prev,
                 bus.state_new, bus.op_err);
        chk({tag, ".resp_valid"}, bus.resp_valid, 1);
        chk({tag, ".bus_op"},     bus.bus_op, eb);
        chk({tag, ".snoop_out"},  bus.snoop_out, es);
        chk({tag, ".state_prev"}, bus.state_prev, ep);
        chk({tag, ".state_new"},  bus.state_new, en);
        chk({tag, ".op_err"},     bus.op_err, eerr);
    endtask

    // Issues a print and watches it until op_ready returns, bounded at 200 cycles.
    task automatic do_print();
        busy = 0; ndump = 0; nresp = 0; resp_bus = 0;
        do_op(OP_PRINT, 0, 0, SNP_NOHIT);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.op_ready) break;
            busy++;
            if (bus.dump_valid) begin
                if (ndump < 8) begin
                    d_addr[ndump]  = {bus.dump_index, bus.dump_way};
                    d_state[ndump] = bus.dump_state;
                end
                ndump++;
            end
            if (bus.resp_valid) begin
                nresp++;
                resp_bus = bus.bus_op;
            end
        end
        $display("txn print: busy=%0d dumps=%0d resp=%0d", busy, ndump, nresp);
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.opcode   = 4'd0;
        bus.index    = '0;
        bus.way      = '0;
        bus.snoop_in = SNP_NOHIT;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("reset.op_ready",   bus.op_ready, 1);
        chk("reset.resp_valid", bus.resp_valid, 0);
        chk("reset.bus_op",     bus.bus_op, BUS_NOP);
        chk("reset.snoop_out",  bus.snoop_out, SNP_NOHIT);
        chk("reset.state_prev", bus.state_prev, LN_I);
        chk("reset.state_new",  bus.state_new, LN_I);
        chk("reset.op_err",     bus.op_err, 0);
        chk("reset.dump_valid", bus.dump_valid, 0);
        chk("reset.dump_index", bus.dump_index, 0);
        chk("reset.dump_way",   bus.dump_way, 0);

        do_op(OP_RD_L1D, 3, 1, SNP_NOHIT);
        chk_resp("rd_miss_nohit", BUS_READ, SNP_NOHIT, LN_I, LN_E, 1'b0);
        do_op(OP_RD_L1D, 3, 1, SNP_NOHIT);
        chk_resp("rd_hit_e", BUS_NOP, SNP_NOHIT, LN_E, LN_E, 1'b0);
        @(posedge clk);
        #1;
        chk("idle.resp_valid", bus.resp_valid, 0);

        do_op(OP_RD_L1D, 5, 0, SNP_HIT);
        chk_resp("rd_miss_hit", BUS_READ, SNP_NOHIT, LN_I, LN_F, 1'b0);
        do_op(OP_SNP_RD, 5, 0, SNP_NOHIT);
        chk_resp("snprd_f", BUS_NOP, SNP_HIT, LN_F, LN_S, 1'b0);
        do_op(OP_WR_L1D, 5, 0, SNP_NOHIT);
        chk_resp("wr_s", BUS_INVAL, SNP_NOHIT, LN_S, LN_M, 1'b0);
        do_op(OP_SNP_RFO, 5, 0, SNP_NOHIT);
        chk_resp("snprfo_m", BUS_WRITE, SNP_HITM, LN_M, LN_I, 1'b0);

        do_op(OP_WR_L1D, 2, 3, SNP_NOHIT);
        chk_resp("wr_i", BUS_RFO, SNP_NOHIT, LN_I, LN_M, 1'b0);
        do_op(OP_SNP_RD, 2, 3, SNP_NOHIT);
        chk_resp("snprd_m", BUS_WRITE, SNP_HITM, LN_M, LN_S, 1'b0);
        do_op(OP_RD_L1I, 15, 3, SNP_HITM);
        chk_resp("rdi_miss_hitm", BUS_READ, SNP_NOHIT, LN_I, LN_F, 1'b0);

        // Non-I lines now: (2,3)=S addr 11, (3,1)=E addr 13, (15,3)=F addr 63.
        do_print();
        chk("print.busy_cycles", busy, 65);
        chk("print.dump_count", ndump, 3);
        chk("print.resp_count", nresp, 1);
        chk("print.resp_bus_op", resp_bus, BUS_NOP);
        chk("print.dump0_addr", d_addr[0], 11);
        chk("print.dump0_state", d_state[0], LN_S);
        chk("print.dump1_addr", d_addr[1], 13);
        chk("print.dump1_state", d_state[1], LN_E);
        chk("print.dump2_addr", d_addr[2], 63);
        chk("print.dump2_state", d_state[2], LN_F);

        do_op(OP_PRINT, 0, 0, SNP_NOHIT);
        repeat (10) @(negedge clk);
        chk("sweep.op_ready_low", bus.op_ready, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort.op_ready", bus.op_ready, 1);
        chk("abort.resp_valid", bus.resp_valid, 0);
        nresp = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus.resp_valid) nresp++;
        end
        chk("abort.no_resp", nresp, 0);
        do_print();
        chk("abort.busy_cycles", busy, 65);
        chk("abort.dump_count", ndump, 0);

        do_op(OP_WR_L1D, 7, 2, SNP_NOHIT);
        chk_resp("wr_i_b", BUS_RFO, SNP_NOHIT, LN_I, LN_M, 1'b0);
        do_op(OP_CLEAR, 7, 2, SNP_NOHIT);
        chk_resp("clear", BUS_NOP, SNP_NOHIT, LN_I, LN_I, 1'b0);
        do_op(OP_SNP_WR, 7, 2, SNP_NOHIT);
        chk_resp("after_clear", BUS_NOP, SNP_NOHIT, LN_I, LN_I, 1'b0);

        do_op(OP_RD_L1D, 7, 2, SNP_NOHIT);
        chk_resp("rd_miss_b", BUS_READ, SNP_NOHIT, LN_I, LN_E, 1'b0);
        do_op(4'd7, 7, 2, SNP_NOHIT);
        chk_resp("illegal7", BUS_NOP, SNP_NOHIT, LN_E, LN_E, 1'b1);
        do_op(4'd12, 7, 2, SNP_NOHIT);
        chk_resp("illegal12", BUS_NOP, SNP_NOHIT, LN_E, LN_E, 1'b1);
        do_op(OP_SNP_WR, 7, 2, SNP_NOHIT);
        chk_resp("after_illegal", BUS_NOP, SNP_NOHIT, LN_E, LN_E, 1'b0);
        do_op(OP_SNP_INV, 7, 2, SNP_NOHIT);
        chk_resp("snpinv_e", BUS_NOP, SNP_NOHIT, LN_E, LN_E, 1'b0);

`ifdef MESIF_STATS_EN
        do_op(OP_CLEAR, 0, 0, SNP_NOHIT);
        chk("stats.clr_hit", hit_cnt, 0);
        chk("stats.clr_miss", miss_cnt, 0);
        chk("stats.clr_wb", wbk_cnt, 0);
        for (int i = 8; i < 13; i++) do_op(OP_RD_L1D, i, 0, SNP_NOHIT);
        chk("stats.miss_sat", miss_cnt, 3);
        chk("stats.hit_zero", hit_cnt, 0);
        do_op(OP_RD_L1D, 8, 0, SNP_NOHIT);
        do_op(OP_WR_L1D, 9, 0, SNP_NOHIT);
        do_op(OP_SNP_RD, 9, 0, SNP_NOHIT);
        chk_resp("stats.snprd_m", BUS_WRITE, SNP_HITM, LN_M, LN_S, 1'b0);
        chk("stats.hit", hit_cnt, 2);
        chk("stats.wb", wbk_cnt, 1);
        do_op(OP_CLEAR, 0, 0, SNP_NOHIT);
        chk("stats.clr2_hit", hit_cnt, 0);
        chk("stats.clr2_miss", miss_cnt, 0);
        chk("stats.clr2_wb", wbk_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
